// File: rtl/id_decode_stage.sv
// MIPS instruction-decode stage: IF/ID capture register, field/control decode,
// and a 32x32 register file with write-first bypass into the captured operands.
module id_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_VALID,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_INST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        WB_EN,
  input  logic [4:0]  WB_ADDR,
  input  logic [31:0] WB_DATA,
  output logic        ID_VALID,
  output logic [31:0] ID_PC,
  output logic [4:0]  ID_RS,
  output logic [4:0]  ID_RT,
  output logic [4:0]  ID_DST,
  output logic [4:0]  ID_SHAMT,
  output logic [5:0]  ID_FUNCT,
  output logic [5:0]  ID_OPCODE,
  output logic [31:0] ID_IMM,
  output logic [31:0] ID_RS_DATA,
  output logic [31:0] ID_RT_DATA,
  output logic [7:0]  ID_CTRL,
  output logic        ID_ILLEGAL
);

  localparam logic [7:0] C_REG_WRITE = 8'h01;
  localparam logic [7:0] C_REG_DST   = 8'h02;
  localparam logic [7:0] C_ALU_IMM   = 8'h04;
  localparam logic [7:0] C_MEM_READ  = 8'h08;
  localparam logic [7:0] C_MEM_WRITE = 8'h10;
  localparam logic [7:0] C_BRANCH    = 8'h20;
  localparam logic [7:0] C_JUMP      = 8'h40;
  localparam logic [7:0] C_IMM_ZEXT  = 8'h80;

  logic [31:0] rf [0:31];

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [7:0]  dec_ctrl;
  logic [4:0]  dec_dst;
  logic        dec_ill;
  logic [31:0] dec_imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign op = IF_INST[31:26];
  assign fn = IF_INST[5:0];
  assign rs = IF_INST[25:21];
  assign rt = IF_INST[20:16];
  assign rd = IF_INST[15:11];

  always_comb begin
    dec_ctrl = 8'h00;
    dec_dst  = 5'd0;
    dec_ill  = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02: begin
            dec_ctrl = C_REG_WRITE | C_REG_DST;
            dec_dst  = rd;
          end
          6'h08: begin
            dec_ctrl = C_JUMP;
            dec_dst  = rd;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08: begin
        dec_ctrl = C_REG_WRITE | C_ALU_IMM;
        dec_dst  = rt;
      end
      6'h0c, 6'h0d, 6'h0f: begin
        dec_ctrl = C_REG_WRITE | C_ALU_IMM | C_IMM_ZEXT;
        dec_dst  = rt;
      end
      6'h23: begin
        dec_ctrl = C_REG_WRITE | C_ALU_IMM | C_MEM_READ;
        dec_dst  = rt;
      end
      6'h2b: begin
        dec_ctrl = C_ALU_IMM | C_MEM_WRITE;
        dec_dst  = rt;
      end
      6'h04, 6'h05: begin
        dec_ctrl = C_BRANCH;
        dec_dst  = rt;
      end
      6'h02: dec_ctrl = C_JUMP;
      6'h03: begin
        dec_ctrl = C_JUMP | C_REG_WRITE;
        dec_dst  = 5'd31;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    if (op == 6'h02 || op == 6'h03) begin
      dec_imm = {4'b0000, IF_INST[25:0], 2'b00};
    end else if (dec_ctrl[7]) begin
      dec_imm = {16'h0000, IF_INST[15:0]};
    end else begin
      dec_imm = {{16{IF_INST[15]}}, IF_INST[15:0]};
    end
  end

  // A write landing on the same edge as the capture must be visible to it.
  always_comb begin
    rs_val = rf[rs];
    rt_val = rf[rt];
    if (WB_EN && WB_ADDR != 5'd0 && WB_ADDR == rs) rs_val = WB_DATA;
    if (WB_EN && WB_ADDR != 5'd0 && WB_ADDR == rt) rt_val = WB_DATA;
    if (rs == 5'd0) rs_val = 32'h0;
    if (rt == 5'd0) rt_val = 32'h0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (WB_EN && WB_ADDR != 5'd0) begin
      rf[WB_ADDR] <= WB_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST || FLUSH) begin
      ID_VALID   <= 1'b0;
      ID_PC      <= RESET_PC;
      ID_RS      <= 5'd0;
      ID_RT      <= 5'd0;
      ID_DST     <= 5'd0;
      ID_SHAMT   <= 5'd0;
      ID_FUNCT   <= 6'd0;
      ID_OPCODE  <= 6'd0;
      ID_IMM     <= 32'h0;
      ID_RS_DATA <= 32'h0;
      ID_RT_DATA <= 32'h0;
      ID_CTRL    <= 8'h00;
      ID_ILLEGAL <= 1'b0;
    end else if (!STALL) begin
      ID_VALID   <= IF_VALID;
      ID_PC      <= IF_PC;
      ID_RS      <= rs;
      ID_RT      <= rt;
      ID_DST     <= dec_dst;
      ID_SHAMT   <= IF_INST[10:6];
      ID_FUNCT   <= fn;
      ID_OPCODE  <= op;
      ID_IMM     <= dec_imm;
      ID_RS_DATA <= rs_val;
      ID_RT_DATA <= rt_val;
      ID_CTRL    <= IF_VALID ? dec_ctrl : 8'h00;
      ID_ILLEGAL <= IF_VALID ? dec_ill : 1'b0;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: a reference register-file/decode model
// pushes expected ID_* snapshots into a queue that is popped after each edge.
module tb_id_decode_stage;

  localparam logic [31:0] TB_RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic        full;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  dst;
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [7:0]  ctrl;
    logic        ill;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IF_VALID = 1'b0;
  logic [31:0] IF_PC = 32'h0;
  logic [31:0] IF_INST = 32'h0;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic        WB_EN = 1'b0;
  logic [4:0]  WB_ADDR = 5'd0;
  logic [31:0] WB_DATA = 32'h0;
  logic        ID_VALID;
  logic [31:0] ID_PC;
  logic [4:0]  ID_RS;
  logic [4:0]  ID_RT;
  logic [4:0]  ID_DST;
  logic [4:0]  ID_SHAMT;
  logic [5:0]  ID_FUNCT;
  logic [5:0]  ID_OPCODE;
  logic [31:0] ID_IMM;
  logic [31:0] ID_RS_DATA;
  logic [31:0] ID_RT_DATA;
  logic [7:0]  ID_CTRL;
  logic        ID_ILLEGAL;

  id_decode_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IF_PC(IF_PC), .IF_INST(IF_INST),
    .STALL(STALL), .FLUSH(FLUSH), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .ID_VALID(ID_VALID), .ID_PC(ID_PC), .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_DST(ID_DST),
    .ID_SHAMT(ID_SHAMT), .ID_FUNCT(ID_FUNCT), .ID_OPCODE(ID_OPCODE), .ID_IMM(ID_IMM),
    .ID_RS_DATA(ID_RS_DATA), .ID_RT_DATA(ID_RT_DATA), .ID_CTRL(ID_CTRL), .ID_ILLEGAL(ID_ILLEGAL)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  exp_t        last_exp;
  logic [31:0] model_rf [0:31];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e = '0;
    e.full = 1'b1;
    e.pc = TB_RESET_PC;
    return e;
  endfunction

  // Reference decode written straight from the opcode/funct table.
  function automatic void ref_decode(input logic [31:0] inst, output logic [7:0] ctrl,
                                     output logic [4:0] dst, output logic [31:0] imm,
                                     output logic ill);
    logic [5:0] op;
    logic [5:0] fn;
    op = inst[31:26];
    fn = inst[5:0];
    ill = 1'b0;
    case (op)
      6'b000000: ctrl = (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                    6'b000000, 6'b000010}) ? 8'h03 :
                        (fn == 6'b001000) ? 8'h40 : 8'h00;
      6'b001000: ctrl = 8'h05;
      6'b001100, 6'b001101, 6'b001111: ctrl = 8'h85;
      6'b100011: ctrl = 8'h0D;
      6'b101011: ctrl = 8'h14;
      6'b000100, 6'b000101: ctrl = 8'h20;
      6'b000010: ctrl = 8'h40;
      6'b000011: ctrl = 8'h41;
      default:   ctrl = 8'h00;
    endcase
    if (ctrl == 8'h00) ill = 1'b1;
    if (ill)                 dst = 5'd0;
    else if (op == 6'b000000) dst = inst[15:11];
    else if (op == 6'b000011) dst = 5'd31;
    else if (op == 6'b000010) dst = 5'd0;
    else                      dst = inst[20:16];
    if (op == 6'b000010 || op == 6'b000011) imm = {4'b0000, inst[25:0], 2'b00};
    else if (ctrl[7])                       imm = {16'h0000, inst[15:0]};
    else                                    imm = {{16{inst[15]}}, inst[15:0]};
  endfunction

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".valid"}, {31'b0, ID_VALID}, {31'b0, e.valid});
    check({tag, ".pc"}, ID_PC, e.pc);
    check({tag, ".ctrl"}, {24'b0, ID_CTRL}, {24'b0, e.ctrl});
    check({tag, ".illegal"}, {31'b0, ID_ILLEGAL}, {31'b0, e.ill});
    if (e.full) begin
      check({tag, ".fields"}, {5'b0, ID_OPCODE, ID_RS, ID_RT, ID_SHAMT, ID_FUNCT},
            {5'b0, e.inst[31:16], e.inst[10:0]});
      check({tag, ".dst"}, {27'b0, ID_DST}, {27'b0, e.dst});
      check({tag, ".imm"}, ID_IMM, e.imm);
      check({tag, ".rs_data"}, ID_RS_DATA, e.rs_data);
      check({tag, ".rt_data"}, ID_RT_DATA, e.rt_data);
    end
  endtask

  // Driver: called #1 after a posedge; drives one edge's inputs and checks its result.
  task automatic step(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic stall, input logic flush, input logic wb_en,
                      input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    logic [7:0]  c;
    logic [4:0]  d;
    logic [31:0] im;
    logic        il;
    IF_VALID = v; IF_PC = pc; IF_INST = inst;
    STALL = stall; FLUSH = flush; WB_EN = wb_en; WB_ADDR = wa; WB_DATA = wd;
    if (wb_en && wa != 5'd0) model_rf[wa] = wd;
    if (flush) begin
      e = reset_exp();
    end else if (stall) begin
      e = last_exp;
    end else begin
      ref_decode(inst, c, d, im, il);
      e.full = v;
      e.valid = v;
      e.pc = pc;
      e.inst = inst;
      e.dst = d;
      e.imm = im;
      e.rs_data = model_rf[inst[25:21]];
      e.rt_data = model_rf[inst[20:16]];
      e.ctrl = v ? c : 8'h00;
      e.ill = v ? il : 1'b0;
    end
    exp_q.push_back(e);
    last_exp = e;
    @(posedge CLK);
    #1;
    WB_EN = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      compare(tag, exp_q.pop_front());
    end
  endtask

  task automatic cap(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    step(tag, 1'b1, pc, inst, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    logic [5:0]  ops [12];
    logic [5:0]  fns [8];
    logic [31:0] inst;
    logic [31:0] pc;
    ops = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02, 6'h08};
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    last_exp = reset_exp();
    compare("reset", last_exp);

    // every register reads zero after reset
    for (int i = 1; i < 32; i++) begin
      inst = {6'h00, i[4:0], 5'(31 - i), 5'd1, 5'd0, 6'h20};
      cap("rf_zero", 32'(i * 4), inst);
    end

    cap("addi", 32'h4, 32'h2008_0005);
    check("addi.ctrl_lit", {24'b0, ID_CTRL}, 32'h05);
    step("bypass", 1'b1, 32'h8, 32'h8D09_0004, 1'b0, 1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF);
    check("bypass.rs_lit", ID_RS_DATA, 32'hDEAD_BEEF);
    cap("andi", 32'hC, 32'h3008_FFFF);
    check("andi.imm_lit", ID_IMM, 32'h0000_FFFF);
    cap("addi_neg", 32'h10, 32'h2008_FFFF);
    check("addi_neg.imm_lit", ID_IMM, 32'hFFFF_FFFF);
    cap("jal", 32'h14, 32'h0C00_0123);
    check("jal.dst_lit", {27'b0, ID_DST}, 32'd31);
    cap("j", 32'h18, 32'h0800_0040);
    cap("jr", 32'h1C, 32'h03E0_0008);
    cap("sw", 32'h20, 32'hAD09_FFF8);
    cap("bne", 32'h24, 32'h1509_FFFE);

    // stall holds outputs even across a write to a source register
    step("stall1", 1'b1, 32'h28, 32'h0128_5020, 1'b1, 1'b0, 1'b1, 5'd9, 32'h1111_2222);
    step("stall2", 1'b1, 32'h2C, 32'h3C0A_1234, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step("stall3", 1'b0, 32'h30, 32'hFC00_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step("stall_flush", 1'b1, 32'h34, 32'h2008_0005, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    check("stall_flush.valid_lit", {31'b0, ID_VALID}, 32'd0);
    cap("after_flush", 32'h38, 32'h0128_5020);

    cap("illegal_op", 32'h3C, 32'hFC00_0000);
    check("illegal_op.lit", {31'b0, ID_ILLEGAL}, 32'd1);
    cap("illegal_fn", 32'h40, 32'h0128_503F);
    step("invalid", 1'b0, 32'h44, 32'hFC00_0000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("wr_r0", 1'b0, 32'h48, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
    cap("rd_r0", 32'h4C, 32'h0000_0820);
    cap("nop", 32'h50, 32'h0000_0000);

    // randomized mix
    for (int n = 0; n < 120; n++) begin
      inst = $urandom();
      if ($urandom_range(0, 7) != 0) begin
        inst[31:26] = ops[$urandom_range(0, 11)];
        if (inst[31:26] == 6'h00) inst[5:0] = fns[$urandom_range(0, 7)];
      end
      pc = $urandom() & 32'hFFFF_FFFC;
      step("rand", $urandom_range(0, 7) != 0, pc, inst, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)), $urandom());
    end

    // asynchronous reset in the middle of a stall clears outputs and registers at once
    step("pre_rst_wr", 1'b1, 32'h60, 32'h2005_0007, 1'b0, 1'b0, 1'b1, 5'd5, 32'hCAFE_F00D);
    cap("pre_rst_rd", 32'h64, 32'h00A5_2820);
    STALL = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    last_exp = reset_exp();
    compare("mid_rst", last_exp);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    compare("mid_rst_held", last_exp);
    STALL = 1'b0;
    cap("post_rst_rd", 32'h68, 32'h00A5_2820);
    check("post_rst_rd.rs_lit", ID_RS_DATA, 32'h0);

    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
